pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined core (fetch, decode, execute, memory, writeback).
- Keeps its own shadow pipeline of destination tags for the EX, MEM and WB stages, fed from the decode stage.
- Produces stall, bubble, flush and operand-forwarding selects.
- Keeps saturating stall and flush performance counters.
- Replaces the opcode-history hazard detection with register-tag scoreboarding.

Parameters:
RA_W, 4, register-address width (number of registers = 2**RA_W)
FWD_EN, 1, 1 = forward from MEM/WB and stall only on load-use; 0 = stall until the producer leaves WB
R0_ZERO, 0, 1 = register 0 is hardwired and never causes a hazard
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  reset
dec_valid  in  1  a valid instruction is in decode
dec_ra  in  3*RA_W  source addresses {ra3,ra2,ra1}
dec_use  in  3  per-operand read enable
dec_wr_en  in  1  decode instruction writes the register file
dec_wa  in  RA_W  destination address
dec_is_load  in  1  decode instruction is a RAM load
ex_branch_taken  in  1  instruction in EX redirects the PC
stall  out  1  hold PC and the FetchDecode register
bubble_de  out  1  load a NOP into the DecodeExecute register
flush_fd  out  1  clear the FetchDecode register
flush_de  out  1  clear the DecodeExecute register
fwd_sel  out  6  per EX operand {op3,op2,op1}, 2b each: 0 regfile, 1 MEM, 2 WB
stall_cnt  out  CNT_W  cycles with stall=1
flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
Reset and slots
- Reset is rst, asynchronous, active-high; clock is clk.
- On reset: slots EX, MEM and WB are invalid, counters are 0, and every output is 0.
- Each slot holds {valid, wr_en, wa, is_load, ra[3], use[3]}.
- Slots advance every clk: WB<=MEM, MEM<=EX.
- EX loads the decode info when dec_valid=1, stall=0 and flush_de=0. Otherwise EX becomes invalid (bubble).

Match rule
- Operand i of decode matches slot S when all hold: dec_use[i], S.valid, S.wr_en, dec_ra[i]==S.wa, and not (R0_ZERO && dec_ra[i]==0).

Stall, FWD_EN=1
- stall = dec_valid && any operand matches EX && EX.is_load.
- This is a 1-cycle load-use stall.

Stall, FWD_EN=0
- stall = dec_valid && any operand matches EX, MEM or WB.
- The register file writes at the clock edge that ends WB, so a WB match also stalls.

Bubble
- bubble_de = stall && !ex_branch_taken.

Flush
- flush_fd = flush_de = ex_branch_taken.
- Flush overrides stall: when ex_branch_taken=1, stall=0 and bubble_de=0.

Forwarding
- fwd_sel is for the instruction in EX, compared against the MEM and WB slots with the same match rule using EX.ra/EX.use.
- MEM match with !MEM.is_load gives 1; else a WB match gives 2; else 0. MEM has priority over WB.
- fwd_sel is forced to 0 when FWD_EN=0 or EX is invalid.

Timing and counters
- All outputs except the counters are combinational from the slots and decode inputs, with zero-cycle latency.
- stall_cnt increments each cycle stall=1; flush_cnt increments each cycle ex_branch_taken=1.
- Both counters saturate at all-ones.

Boundaries
- dec_valid=0 gives no stall; stall and bubble are never asserted for an invalid decode.
- An instruction that both reads and writes the same register compares only against older slots, never against itself.
- Back-to-back load-use stalls cause exactly 1 stall cycle per producer; after one cycle the load is in MEM and forwards at WB.
- Reset asserted mid-stall clears everything immediately; the first cycle after release shows no hazard.

Test Plan:
1. FWD_EN=1: ADD r3 (wr r3) then SUB using r3 on op1 -> stall=0; next cycle fwd_sel[1:0]=1; one cycle later a third instruction using r3 -> fwd_sel=2.
2. FWD_EN=1: LOAD r5 then ADD using r5 -> stall=1 and bubble_de=1 for exactly 1 cycle, stall_cnt=1; then fwd_sel op=2 in EX.
3. FWD_EN=0: ADD r2 then a reader of r2 -> stall=1 for 3 consecutive cycles, stall_cnt=3, fwd_sel stays 0.
4. Load-use stall with ex_branch_taken=1 in the same cycle -> flush_fd=flush_de=1, stall=0, bubble_de=0, flush_cnt=1; EX slot invalid next cycle.
5. R0_ZERO=1: write r0 then read r0 -> no stall, fwd_sel=0. R0_ZERO=0: same sequence forwards with fwd_sel=1.
6. CNT_W=4: hold a FWD_EN=0 stall for 20 cycles -> stall_cnt sticks at 15. Assert rst mid-stall -> counters 0 and outputs 0 asynchronously.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: a shadow pipeline of
// destination tags (EX/MEM/WB) drives stall, bubble, flush and forward selects.

module phc_opnd_match #(
  parameter int RA_W    = 4,
  parameter int R0_ZERO = 0
) (
  input  logic                 rd_en_i,
  input  logic [RA_W-1:0]      ra_i,
  input  logic [2:0]           wr_vld_i,
  input  logic [2:0][RA_W-1:0] wa_i,
  output logic [2:0]           hit_o
);
  logic r0_skip;
  assign r0_skip = (R0_ZERO != 0) && (ra_i == '0);

  always_comb begin
    hit_o = '0;
    for (int s = 0; s < 3; s++)
      hit_o[s] = rd_en_i && wr_vld_i[s] && (wa_i[s] == ra_i) && !r0_skip;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int RA_W    = 4,
  parameter int FWD_EN  = 1,
  parameter int R0_ZERO = 0,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec_valid,
  input  logic [3*RA_W-1:0]   dec_ra,
  input  logic [2:0]          dec_use,
  input  logic                dec_wr_en,
  input  logic [RA_W-1:0]     dec_wa,
  input  logic                dec_is_load,
  input  logic                ex_branch_taken,
  output logic                stall,
  output logic                bubble_de,
  output logic                flush_fd,
  output logic                flush_de,
  output logic [5:0]          fwd_sel,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);
  typedef struct packed {
    logic                 vld;
    logic                 wr_en;
    logic [RA_W-1:0]      wa;
    logic                 is_load;
    logic [2:0][RA_W-1:0] ra;
    logic [2:0]           rd_en;
  } slot_t;

  slot_t dec_s, ex_d, ex_q, mem_q, wb_q;

  // Decode compares against slots 0=EX,1=MEM,2=WB; EX compares against 0=MEM,1=WB.
  logic [2:0]           dec_wv, ex_wv;
  logic [2:0][RA_W-1:0] dec_wa_v, ex_wa_v;
  logic [2:0][2:0]      dec_hit, ex_hit;
  logic                 haz;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    dec_s.vld     = dec_valid;
    dec_s.wr_en   = dec_wr_en;
    dec_s.wa      = dec_wa;
    dec_s.is_load = dec_is_load;
    dec_s.ra      = dec_ra;
    dec_s.rd_en   = dec_use;
  end

  assign dec_wv   = {wb_q.vld && wb_q.wr_en, mem_q.vld && mem_q.wr_en, ex_q.vld && ex_q.wr_en};
  assign dec_wa_v = {wb_q.wa, mem_q.wa, ex_q.wa};
  assign ex_wv    = {1'b0, wb_q.vld && wb_q.wr_en, mem_q.vld && mem_q.wr_en};
  assign ex_wa_v  = {{RA_W{1'b0}}, wb_q.wa, mem_q.wa};

  for (genvar i = 0; i < 3; i++) begin : g_op
    phc_opnd_match #(.RA_W(RA_W), .R0_ZERO(R0_ZERO)) u_dec (
      .rd_en_i (dec_use[i]),
      .ra_i    (dec_s.ra[i]),
      .wr_vld_i(dec_wv),
      .wa_i    (dec_wa_v),
      .hit_o   (dec_hit[i])
    );
    phc_opnd_match #(.RA_W(RA_W), .R0_ZERO(R0_ZERO)) u_ex (
      .rd_en_i (ex_q.rd_en[i]),
      .ra_i    (ex_q.ra[i]),
      .wr_vld_i(ex_wv),
      .wa_i    (ex_wa_v),
      .hit_o   (ex_hit[i])
    );
  end

  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (FWD_EN != 0) haz = haz | (dec_hit[i][0] && ex_q.is_load);
      else             haz = haz | (|dec_hit[i]);
    end
    // A taken branch kills the decode instruction, so it never stalls.
    stall     = !rst && dec_valid && haz && !ex_branch_taken;
    bubble_de = stall;
    flush_fd  = !rst && ex_branch_taken;
    flush_de  = flush_fd;

    // A loaded value is not ready in MEM, so a MEM load falls through to WB.
    fwd_sel = '0;
    if (FWD_EN != 0 && ex_q.vld) begin
      for (int i = 0; i < 3; i++) begin
        if (ex_hit[i][0] && !mem_q.is_load) fwd_sel[2*i +: 2] = 2'd1;
        else if (ex_hit[i][1])              fwd_sel[2*i +: 2] = 2'd2;
      end
    end

    ex_d        = (dec_valid && !stall && !flush_de) ? dec_s : '0;
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_fd && !(&flush_cnt_q)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  logic unused_bits;
  assign unused_bits = ^{mem_q.ra, mem_q.rd_en, wb_q.is_load, wb_q.ra, wb_q.rd_en,
                         ex_hit[0][2], ex_hit[1][2], ex_hit[2][2]};
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Three controller configurations driven by a directed prologue then random
// instruction streams; a scoreboard compares every cycle against an age-based model.

module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        dv[3], dwr[3], dld[3], br[3];
  logic [11:0] dra[3];
  logic [2:0]  duse[3];
  logic [3:0]  dwa[3];
  logic        st[3], bb[3], ffd[3], fde[3];
  logic [5:0]  fw[3];
  logic [15:0] sc0, sc2, fc0, fc2;
  logic [3:0]  sc1, fc1;

  // u0: forwarding; u1: no forwarding, 4-bit counters; u2: forwarding, r0 hardwired
  localparam int FWD [3]  = '{1, 0, 1};
  localparam int R0Z [3]  = '{0, 0, 1};
  localparam int CMAX [3] = '{65535, 15, 65535};

  pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(1), .R0_ZERO(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .dec_valid(dv[0]), .dec_ra(dra[0]), .dec_use(duse[0]),
    .dec_wr_en(dwr[0]), .dec_wa(dwa[0]), .dec_is_load(dld[0]), .ex_branch_taken(br[0]),
    .stall(st[0]), .bubble_de(bb[0]), .flush_fd(ffd[0]), .flush_de(fde[0]),
    .fwd_sel(fw[0]), .stall_cnt(sc0), .flush_cnt(fc0));
  pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(0), .R0_ZERO(0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .dec_valid(dv[1]), .dec_ra(dra[1]), .dec_use(duse[1]),
    .dec_wr_en(dwr[1]), .dec_wa(dwa[1]), .dec_is_load(dld[1]), .ex_branch_taken(br[1]),
    .stall(st[1]), .bubble_de(bb[1]), .flush_fd(ffd[1]), .flush_de(fde[1]),
    .fwd_sel(fw[1]), .stall_cnt(sc1), .flush_cnt(fc1));
  pipe_hazard_ctrl #(.RA_W(4), .FWD_EN(1), .R0_ZERO(1), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .dec_valid(dv[2]), .dec_ra(dra[2]), .dec_use(duse[2]),
    .dec_wr_en(dwr[2]), .dec_wa(dwa[2]), .dec_is_load(dld[2]), .ex_branch_taken(br[2]),
    .stall(st[2]), .bubble_de(bb[2]), .flush_fd(ffd[2]), .flush_de(fde[2]),
    .fwd_sel(fw[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  typedef struct packed {
    bit v; bit wr; bit [3:0] wa; bit ld; bit [2:0][3:0] ra; bit [2:0] rd;
  } ins_t;
  typedef struct packed { ins_t i; bit b; } stim_t;
  typedef struct packed {
    bit st; bit bb; bit ff; bit fd; bit [5:0] fw; bit [31:0] sc; bit [31:0] fc;
  } exp_t;

  // older[k][d]: instruction that left decode d+1 cycles ago (bubbles are invalid)
  ins_t  older[3][3];
  int    scnt[3], fcnt[3];
  exp_t  sbq[3][$];
  stim_t dl[$];
  int    total = 0, fails = 0;

  function automatic ins_t mk(bit v, bit wr, int wa, bit ld, int r1, int r2, int r3, bit [2:0] rd);
    ins_t x;
    x.v = v; x.wr = wr; x.wa = 4'(wa); x.ld = ld;
    x.ra[0] = 4'(r1); x.ra[1] = 4'(r2); x.ra[2] = 4'(r3); x.rd = rd;
    return x;
  endfunction

  function automatic bit produces(ins_t p, bit [3:0] r, int k);
    return p.v && p.wr && p.wa == r && !(R0Z[k] == 1 && r == 4'd0);
  endfunction

  function automatic exp_t predict(int k, ins_t d, bit b, bit r);
    exp_t e;
    bit haz;
    ins_t x;
    e = '0;
    haz = 1'b0;
    for (int i = 0; i < 3; i++)
      if (d.v && d.rd[i])
        for (int a = 0; a < 3; a++)
          if (produces(older[k][a], d.ra[i], k))
            if (FWD[k] == 0 || (a == 0 && older[k][0].ld)) haz = 1'b1;
    e.st = !r && haz && !b;
    e.bb = e.st;
    e.ff = !r && b;
    e.fd = e.ff;
    x = older[k][0];
    if (FWD[k] == 1 && !r && x.v)
      for (int i = 0; i < 3; i++)
        if (x.rd[i]) begin
          if (produces(older[k][1], x.ra[i], k) && !older[k][1].ld) e.fw[2*i +: 2] = 2'd1;
          else if (produces(older[k][2], x.ra[i], k))               e.fw[2*i +: 2] = 2'd2;
        end
    e.sc = r ? 0 : 32'(scnt[k]);
    e.fc = r ? 0 : 32'(fcnt[k]);
    return e;
  endfunction

  task automatic advance(int k, ins_t d, bit b, bit r, exp_t e);
    if (r) begin
      for (int a = 0; a < 3; a++) older[k][a] = '0;
      scnt[k] = 0;
      fcnt[k] = 0;
    end else begin
      older[k][2] = older[k][1];
      older[k][1] = older[k][0];
      older[k][0] = (d.v && !e.st && !b) ? d : '0;
      if (e.st && scnt[k] < CMAX[k]) scnt[k]++;
      if (b && fcnt[k] < CMAX[k]) fcnt[k]++;
    end
  endtask

  function automatic ins_t rnd_ins();
    ins_t x;
    x.v  = ($urandom_range(0, 7) != 0);
    x.wr = ($urandom_range(0, 3) != 0);
    x.ld = ($urandom_range(0, 2) == 0);
    x.wa = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    for (int i = 0; i < 3; i++)
      x.ra[i] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    x.rd = 3'($urandom_range(0, 7));
    return x;
  endfunction

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s u%0d @%0t: got %0d expected %0d", nm, k, $time, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per instance per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    logic [31:0] asc, afc;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++)
        if (sbq[k].size() != 0) begin
          e = sbq[k].pop_front();
          asc = (k == 0) ? 32'(sc0) : (k == 1) ? 32'(sc1) : 32'(sc2);
          afc = (k == 0) ? 32'(fc0) : (k == 1) ? 32'(fc1) : 32'(fc2);
          chk("stall",     k, 32'(st[k]),  32'(e.st));
          chk("bubble_de", k, 32'(bb[k]),  32'(e.bb));
          chk("flush_fd",  k, 32'(ffd[k]), 32'(e.ff));
          chk("flush_de",  k, 32'(fde[k]), 32'(e.fd));
          chk("fwd_sel",   k, 32'(fw[k]),  32'(e.fw));
          chk("stall_cnt", k, asc, e.sc);
          chk("flush_cnt", k, afc, e.fc);
        end
    end
  end

  // Driver
  initial begin
    ins_t  cur[3];
    bit    hold[3], bnow, rnow, did_rst;
    int    di[3], rst_left;
    stim_t s;
    exp_t  e;
    for (int k = 0; k < 3; k++) begin
      dv[k] = 0; dwr[k] = 0; dld[k] = 0; br[k] = 0; dra[k] = '0; duse[k] = '0; dwa[k] = '0;
      for (int a = 0; a < 3; a++) older[k][a] = '0;
      scnt[k] = 0; fcnt[k] = 0; hold[k] = 0; di[k] = 0; cur[k] = '0;
    end
    // directed prologue: ALU fwd chain, load-use, long no-fwd stall, flush vs stall, r0
    s.b = 0;
    s.i = mk(1, 1, 3, 0, 1, 2, 0, 3'b011);  dl.push_back(s);
    s.i = mk(1, 1, 4, 0, 3, 0, 0, 3'b001);  dl.push_back(s);
    s.i = mk(1, 1, 7, 0, 3, 0, 0, 3'b001);  dl.push_back(s);
    s.i = '0; repeat (3) dl.push_back(s);
    s.i = mk(1, 1, 5, 1, 1, 0, 0, 3'b001);  dl.push_back(s);
    s.i = mk(1, 1, 6, 0, 2, 5, 0, 3'b011);  dl.push_back(s);
    s.i = '0; repeat (3) dl.push_back(s);
    s.i = mk(1, 1, 2, 0, 1, 1, 0, 3'b011);  dl.push_back(s);
    s.i = mk(1, 1, 8, 0, 1, 1, 2, 3'b100);  dl.push_back(s);
    s.i = '0; repeat (3) dl.push_back(s);
    s.i = mk(1, 1, 6, 1, 1, 0, 0, 3'b001);  dl.push_back(s);
    s.i = mk(1, 1, 9, 0, 6, 0, 0, 3'b001);  s.b = 1; dl.push_back(s); s.b = 0;
    s.i = '0; repeat (3) dl.push_back(s);
    s.i = mk(1, 1, 0, 0, 1, 2, 0, 3'b011);  dl.push_back(s);
    s.i = mk(1, 1, 10, 0, 0, 0, 0, 3'b001); dl.push_back(s);
    s.i = '0; repeat (3) dl.push_back(s);

    did_rst = 0;
    rst_left = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      #1;
      rnow = (cyc < 2);
      if (!did_rst && cyc >= 250 && (hold[1] || cyc >= 320)) begin
        did_rst = 1;
        rst_left = 2;
      end
      if (rst_left > 0) begin
        rnow = 1;
        rst_left--;
      end
      rst = rnow;
      for (int k = 0; k < 3; k++) begin
        bnow = 0;
        if (rnow) cur[k] = '0;
        else if (hold[k]) bnow = (di[k] >= dl.size()) && ($urandom_range(0, 9) == 0);
        else if (di[k] < dl.size()) begin
          cur[k] = dl[di[k]].i;
          bnow   = dl[di[k]].b;
          di[k]++;
        end else begin
          cur[k] = rnd_ins();
          bnow   = ($urandom_range(0, 9) == 0);
        end
        dv[k] = cur[k].v; dwr[k] = cur[k].wr; dwa[k] = cur[k].wa; dld[k] = cur[k].ld;
        dra[k] = cur[k].ra; duse[k] = cur[k].rd; br[k] = bnow;
        e = predict(k, cur[k], bnow, rnow);
        sbq[k].push_back(e);
        advance(k, cur[k], bnow, rnow, e);
        hold[k] = e.st;
      end
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if (sbq[k].size() != 0) begin
        fails++;
        $display("FAIL drain u%0d: got %0d entries left expected 0", k, sbq[k].size());
      end
    end
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
